// File: rtl/switch_mcu_wb_arbiter_if.sv
// Write-back bus between the execution units, the arbiter and the register file.
// The arbiter connects through the slave modport; the unit/sequencer side uses master.
interface switch_mcu_wb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic                      in_flush;
  logic [NUM_REQ-1:0]        in_wen;
  logic [NUM_REQ*ADDR_W-1:0] in_waddr;
  logic [NUM_REQ*DATA_W-1:0] in_wdata;
  logic [NUM_REQ-1:0]        out_busy;
  logic [NUM_REQ-1:0]        out_overflow;
  logic                      out_idle;
  logic [ADDR_W-1:0]         out_waddr;
  logic                      out_wen;
  logic [DATA_W-1:0]         out_wdata;

  modport master (
    output in_flush, in_wen, in_waddr, in_wdata,
    input  out_busy, out_overflow, out_idle, out_waddr, out_wen, out_wdata
  );

  modport slave (
    input  in_flush, in_wen, in_waddr, in_wdata,
    output out_busy, out_overflow, out_idle, out_waddr, out_wen, out_wdata
  );
endinterface

// File: rtl/switch_mcu_wb_arbiter.sv
// Register-file write-port arbiter: every execution unit gets a one-entry
// holding buffer, and the buffers are drained round-robin onto a single
// registered write port. Writes to x0 are discarded on entry.
module switch_mcu_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input logic                  in_clk,
  input logic                  in_rst,
  switch_mcu_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REQ_I = NUM_REQ;
  localparam logic [PTR_W:0] NUM_REQ_W = NUM_REQ_I[PTR_W:0];
  localparam logic [PTR_W-1:0] LAST_REQ = NUM_REQ_W[PTR_W-1:0] - 1'b1;

  logic [NUM_REQ-1:0] valid;
  logic [ADDR_W-1:0]  buf_addr [NUM_REQ];
  logic [DATA_W-1:0]  buf_data [NUM_REQ];
  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] overflow;
  logic               wen_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               gnt_valid;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W:0]     cand;

  // Round-robin pick: first valid buffer after the last granted one, wrapping.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k + 1);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!gnt_valid && valid[cand[PTR_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Buffer capture, grant issue, pointer advance, sticky overflow and flush.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      valid    <= '0;
      ptr      <= LAST_REQ;
      overflow <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_addr[i] <= '0;
        buf_data[i] <= '0;
      end
    end else if (bus.in_flush) begin
      valid   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= gnt_valid;
      waddr_q <= gnt_valid ? buf_addr[gnt_idx] : '0;
      wdata_q <= gnt_valid ? buf_data[gnt_idx] : '0;
      if (gnt_valid) begin
        ptr <= gnt_idx;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.in_wen[i] && (bus.in_waddr[i*ADDR_W +: ADDR_W] != '0)) begin
          if (!valid[i] || (gnt_valid && gnt_idx == PTR_W'(i))) begin
            valid[i]    <= 1'b1;
            buf_addr[i] <= bus.in_waddr[i*ADDR_W +: ADDR_W];
            buf_data[i] <= bus.in_wdata[i*DATA_W +: DATA_W];
          end else begin
            overflow[i] <= 1'b1;
          end
        end else if (gnt_valid && gnt_idx == PTR_W'(i)) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.out_busy     = valid;
  assign bus.out_overflow = overflow;
  assign bus.out_idle     = ~(|valid) & ~wen_q;
  assign bus.out_wen      = wen_q;
  assign bus.out_waddr    = waddr_q;
  assign bus.out_wdata    = wdata_q;
endmodule
